// File: rtl/router_dst_rx_pkg.sv
// Shared router definitions: receive FSM encoding, header field positions
// and the soft-reset timeout that bounds the read delay.
package router_dst_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    HDR,
    HDR_CAP,
    PLD,
    DONE
  } rx_state_e;

  localparam int unsigned LEN_MSB          = 7;
  localparam int unsigned LEN_LSB          = 2;
  localparam int unsigned LEN_W            = LEN_MSB - LEN_LSB + 1;
  localparam int unsigned SOFT_RST_TIMEOUT = 30;
  localparam int unsigned LEFT_W           = 7;
  localparam int unsigned DATA_W           = 8;

endpackage

// File: rtl/router_dst_rx.sv
// Destination-port receiver: reads one packet from the router FIFO, streams
// its payload, checks the trailing parity byte and reports done/abort.
module router_dst_rx
  import router_dst_rx_pkg::*;
#(
  parameter int unsigned READ_DELAY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic              soft_reset,
  output logic              read_enb,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_data_valid,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              pkt_abort,
  output logic              busy
);

  localparam int unsigned DLY_W    = $clog2(SOFT_RST_TIMEOUT);
  // Last DELAY count before HDR; the IDLE cycle that saw vld_out counts as one.
  localparam int unsigned DLY_LAST = (READ_DELAY > 1) ? READ_DELAY - 2 : 0;

  rx_state_e          state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [LEFT_W-1:0]  left_q, left_d;
  logic [DATA_W-1:0]  xor_q, xor_d;
  logic               pend_q, pend_d;
  logic               last_q, last_d;
  logic [DATA_W-1:0]  pkt_data_q, pkt_data_d;
  logic               pdv_q, pdv_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;
  logic               abort_q, abort_d;
  logic               busy_q, busy_d;
  logic               read_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      left_q     <= '0;
      xor_q      <= '0;
      pend_q     <= 1'b0;
      last_q     <= 1'b0;
      pkt_data_q <= '0;
      pdv_q      <= 1'b0;
      len_q      <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      left_q     <= left_d;
      xor_q      <= xor_d;
      pend_q     <= pend_d;
      last_q     <= last_d;
      pkt_data_q <= pkt_data_d;
      pdv_q      <= pdv_d;
      len_q      <= len_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    left_d     = left_q;
    xor_d      = xor_q;
    pend_d     = 1'b0;
    last_d     = 1'b0;
    pkt_data_d = pkt_data_q;
    pdv_d      = 1'b0;
    len_d      = len_q;
    done_d     = 1'b0;
    perr_d     = perr_q;
    abort_d    = 1'b0;
    read_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (vld_out) begin
          dly_d   = '0;
          state_d = (READ_DELAY <= 1) ? HDR : DELAY;
        end
      end
      DELAY: begin
        if (dly_q == DLY_W'(DLY_LAST)) state_d = HDR;
        else                           dly_d   = dly_q + DLY_W'(1);
      end
      HDR: begin
        read_c = vld_out;
        if (vld_out) state_d = HDR_CAP;
      end
      HDR_CAP: begin
        len_d   = data_in[LEN_MSB:LEN_LSB];
        left_d  = LEFT_W'(data_in[LEN_MSB:LEN_LSB]) + LEFT_W'(1);
        xor_d   = data_in;
        state_d = PLD;
      end
      PLD: begin
        // Reads and arrivals pipeline; last_q marks the parity byte in flight.
        read_c = vld_out && (left_q != '0);
        if (read_c) begin
          left_d = left_q - LEFT_W'(1);
          pend_d = 1'b1;
          last_d = (left_q == LEFT_W'(1));
        end
        if (pend_q) begin
          if (last_q) begin
            perr_d  = ((xor_q ^ data_in) != '0);
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            pkt_data_d = data_in;
            pdv_d      = 1'b1;
            xor_d      = xor_q ^ data_in;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flush drops the partial packet wherever the FSM is.
    if (soft_reset && (state_q != IDLE)) begin
      state_d    = IDLE;
      read_c     = 1'b0;
      dly_d      = '0;
      left_d     = '0;
      xor_d      = '0;
      pend_d     = 1'b0;
      last_d     = 1'b0;
      pkt_data_d = pkt_data_q;
      pdv_d      = 1'b0;
      done_d     = 1'b0;
      perr_d     = perr_q;
      abort_d    = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  assign read_enb       = read_c;
  assign pkt_data       = pkt_data_q;
  assign pkt_data_valid = pdv_q;
  assign pkt_len        = len_q;
  assign pkt_done       = done_q;
  assign parity_err     = perr_q;
  assign pkt_abort      = abort_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_router_dst_rx.sv
// Bench for router_dst_rx: a queue-backed FIFO feeds packets and the
// observed payload/done/abort behaviour is scored against packet rules.
module tb_router_dst_rx;

  logic       clk = 1'b0;
  logic       reset, vld_out, soft_reset;
  logic [7:0] data_in;
  logic       read_enb, pkt_data_valid, pkt_done, parity_err, pkt_abort, busy;
  logic [7:0] pkt_data;
  logic [5:0] pkt_len;

  router_dst_rx #(.READ_DELAY(2)) dut (
    .clk(clk), .reset(reset), .vld_out(vld_out), .data_in(data_in),
    .soft_reset(soft_reset), .read_enb(read_enb), .pkt_data(pkt_data),
    .pkt_data_valid(pkt_data_valid), .pkt_len(pkt_len), .pkt_done(pkt_done),
    .parity_err(parity_err), .pkt_abort(pkt_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned fifo[$];
  byte unsigned got[$];
  byte unsigned q[$];
  int   pops, viol, done_cnt, abort_cnt, first_rd, pkt_cyc, stall_mode, stall_done;
  logic rd_s, busy_s, done_perr, sr_req;
  logic [5:0] done_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({read_enb, pkt_data, pkt_data_valid, pkt_len, pkt_done,
                parity_err, pkt_abort, busy});
  endfunction

  // One clock: drive at negedge, observe, then model the FIFO pop after posedge.
  task automatic tick();
    logic stall;
    @(negedge clk);
    stall = (stall_mode == 1) ? ($urandom_range(0, 3) == 0)
                              : ((stall_mode == 2) && (pops == 3) && (stall_done < 4));
    if (stall && stall_mode == 2) stall_done++;
    vld_out    = (fifo.size() != 0) && !stall;
    soft_reset = sr_req;
    #1;
    rd_s   = read_enb;
    busy_s = busy;
    if (rd_s && (!vld_out || fifo.size() == 0)) viol++;
    if (rd_s && first_rd < 0) first_rd = pkt_cyc;
    if (pkt_data_valid) got.push_back(pkt_data);
    if (pkt_done) begin
      done_cnt++;
      done_perr = parity_err;
      done_len  = pkt_len;
    end
    if (pkt_abort) abort_cnt++;
    pkt_cyc++;
    @(posedge clk);
    #1;
    if (rd_s) begin
      data_in = fifo.pop_front();
      pops++;
    end else begin
      data_in = 8'($urandom);
    end
  endtask

  task automatic start(input byte unsigned pkt[$], input int mode);
    fifo = pkt;
    got.delete();
    pops = 0; viol = 0; done_cnt = 0; abort_cnt = 0;
    first_rd = -1; pkt_cyc = 0; stall_mode = mode; stall_done = 0;
  endtask

  task automatic run_packet(input string name, input byte unsigned pkt[$],
                            input int mode, input bit chk_lat);
    int           exp_len;
    byte unsigned x;
    bit           exp_perr;
    start(pkt, mode);
    for (int i = 0; i < 800 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    exp_len = int'(pkt[0]) >> 2;
    x = 0;
    for (int i = 0; i < pkt.size() - 1; i++) x ^= pkt[i];
    exp_perr = (x != pkt[pkt.size() - 1]);
    chk({name, ".done_cnt"}, 32'(done_cnt), 32'd1);
    chk({name, ".pkt_len"}, 32'(done_len), 32'(exp_len));
    chk({name, ".parity_err"}, 32'(done_perr), 32'(exp_perr));
    chk({name, ".n_payload"}, 32'(got.size()), 32'(exp_len));
    for (int i = 0; i < got.size() && i < exp_len; i++)
      chk({name, ".payload"}, 32'(got[i]), 32'(pkt[i + 1]));
    chk({name, ".n_reads"}, 32'(pops), 32'(pkt.size()));
    chk({name, ".read_violations"}, 32'(viol), 32'd0);
    chk({name, ".busy_after"}, 32'(busy_s), 32'd0);
    if (chk_lat) chk({name, ".first_read"}, 32'(first_rd), 32'd2);
  endtask

  task automatic rand_packet(output byte unsigned pkt[$]);
    int           len;
    byte unsigned x;
    len = ($urandom_range(0, 3) == 0) ? 63 : int'($urandom_range(0, 63));
    pkt.delete();
    pkt.push_back(byte'({6'(len), 2'($urandom)}));
    for (int i = 0; i < len; i++) pkt.push_back(byte'($urandom));
    x = 0;
    foreach (pkt[i]) x ^= pkt[i];
    if ($urandom_range(0, 2) == 0) x ^= byte'($urandom_range(1, 255));
    pkt.push_back(x);
  endtask

  initial begin
    reset = 1'b1; vld_out = 1'b0; soft_reset = 1'b0; data_in = 8'h00; sr_req = 1'b0;
    stall_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_no_read", 32'(viol), 32'd0);

    q = {8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    run_packet("good", q, 0, 1'b1);
    q = {8'h0C, 8'h11, 8'h22, 8'h33, 8'h0D};
    run_packet("bad_parity", q, 0, 1'b1);
    q = {8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    run_packet("stall4", q, 2, 1'b0);
    chk("stall4.stalled", 32'(stall_done), 32'd4);
    q = {8'h00, 8'h00};
    run_packet("empty", q, 0, 1'b1);

    // Flush mid-payload.
    q = {8'h14, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h11};
    start(q, 0);
    for (int i = 0; i < 100 && got.size() < 2; i++) tick();
    chk("sr.in_payload", 32'(got.size()), 32'd2);
    sr_req = 1'b1;
    tick();
    chk("sr.read_enb", 32'(rd_s), 32'd0);
    sr_req = 1'b0;
    fifo.delete();
    tick();
    chk("sr.abort", 32'(abort_cnt), 32'd1);
    chk("sr.busy", 32'(busy_s), 32'd0);
    repeat (5) tick();
    chk("sr.abort_once", 32'(abort_cnt), 32'd1);
    chk("sr.no_done", 32'(done_cnt), 32'd0);

    // Reset mid-payload, then the first read must follow normal delay timing.
    q = {8'h28, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h00};
    start(q, 0);
    for (int i = 0; i < 100 && got.size() < 1; i++) tick();
    chk("rst.in_payload", 32'(got.size()), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst.outputs", all_outs(), 32'd0);
    fifo.delete();
    vld_out = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    viol = 0;
    repeat (3) tick();
    chk("rst.no_read_after", 32'(viol), 32'd0);
    q = {8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    run_packet("after_rst", q, 0, 1'b1);

    // Maximum length exercises the 64-read count.
    q.delete();
    q.push_back(8'hFF);
    for (int i = 0; i < 63; i++) q.push_back(byte'(i * 7 + 1));
    begin
      byte unsigned x = 0;
      foreach (q[i]) x ^= q[i];
      q.push_back(x);
    end
    run_packet("len63", q, 1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      rand_packet(q);
      run_packet("rand", q, int'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_dst_rx.md
ROUTER_DST_RX -- requirements
Module: router_dst_rx

Interface
REQ-001 SHALL have parameter READ_DELAY, default 2, cycles from vld_out high in IDLE to first read_enb; legal range 0..29.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port vld_out  input  1  FIFO non-empty flag from router_sync.
REQ-005 SHALL have port data_in  input  8  FIFO read data, valid the cycle after read_enb is high.
REQ-006 SHALL have port soft_reset  input  1  timeout flush pulse from router_sync for this port.
REQ-007 SHALL have port read_enb  output  1  FIFO read strobe.
REQ-008 SHALL have port pkt_data  output  8  received payload byte.
REQ-009 SHALL have port pkt_data_valid  output  1  one-cycle qualifier per payload byte.
REQ-010 SHALL have port pkt_len  output  6  payload length of the current/last packet.
REQ-011 SHALL have port pkt_done  output  1  one-cycle pulse after the parity byte is received.
REQ-012 SHALL have port parity_err  output  1  valid with pkt_done, held until next pkt_done.
REQ-013 SHALL have port pkt_abort  output  1  one-cycle pulse when a packet is dropped by soft_reset.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 Packet format SHALL be header {len[7:2], addr[1:0]}, then len payload bytes (0..63), then one parity byte.
REQ-016 Parity check SHALL be: XOR of header and all payload bytes equal to the parity byte; otherwise parity_err=1.
REQ-017 FSM states SHALL be IDLE, DELAY, HDR, HDR_CAP, PLD, DONE.
REQ-018 IDLE->DELAY when vld_out=1; DELAY counts READ_DELAY cycles, then ->HDR (READ_DELAY=0: IDLE->HDR directly).
REQ-019 HDR: read_enb=vld_out; on a read ->HDR_CAP; DELAY/HDR with vld_out=0 SHALL hold and keep counting in DELAY.
REQ-020 HDR_CAP: capture data_in as header, load pkt_len=data_in[7:2], set reads_left=len+1, seed running XOR; ->PLD.
REQ-021 PLD: read_enb = vld_out AND reads_left!=0 (combinational, no over-read when FIFO empties); each read decrements reads_left.
REQ-022 Byte arriving the cycle after each PLD read: if it is a payload byte, drive pkt_data and pulse pkt_data_valid and fold into XOR; if it is the final byte, compare as parity.
REQ-023 After the parity byte arrives ->DONE; DONE pulses pkt_done, updates parity_err, ->IDLE next cycle.
REQ-024 vld_out falling mid-packet SHALL only stall reads; byte count and XOR SHALL be preserved.
REQ-025 soft_reset=1 in any non-IDLE state SHALL override all transitions: ->IDLE, read_enb=0, pulse pkt_abort, drop partial XOR, no pkt_done; in IDLE it is ignored.
REQ-026 reads_left SHALL be 7 bits so len=63 (64 reads) does not wrap.

Reset
REQ-027 reset SHALL force IDLE, read_enb=0, pkt_data=0, pkt_data_valid=0, pkt_len=0, pkt_done=0, parity_err=0, pkt_abort=0, busy=0, all counters 0.
REQ-028 Deassertion of reset SHALL not create a read; first read follows REQ-018 timing.

Structure
REQ-029 Shared router package SHALL hold the FSM state encoding, header field positions (LEN_MSB=7, LEN_LSB=2), and soft-reset timeout constant 30.
REQ-030 The block SHALL be a single module; no sub-module.

Verification
REQ-031 Reset mid-PLD -> all outputs 0, state IDLE within same cycle.
REQ-032 READ_DELAY=2, vld_out high at cycle 0, stream 0C,11,22,33,0C -> read_enb first high cycle 2; pkt_data 11,22,33; pkt_len=3, pkt_done with parity_err=0.
REQ-033 Same stream with parity byte 0D -> pkt_done with parity_err=1.
REQ-034 vld_out low for 4 cycles after byte 22 -> read_enb low those cycles, packet completes correctly, no extra read.
REQ-035 soft_reset pulse during PLD -> pkt_abort one cycle, read_enb 0, no pkt_done, busy 0 next cycle.
REQ-036 Header 00, parity 00 -> no pkt_data_valid, pkt_len=0, pkt_done with parity_err=0.
